sr_bank_driver: RTL and testbench

Excitation-side controller for a bank of SR flip-flops. Accepts a target word over a valid/ready handshake and computes the per-bit set/reset excitation against the bank's fed-back state. It drives `s`/`r` for exactly one cycle, never driving the invalid `s=r=1` code, then watches the bank's `q` feedback until it matches the target or a timeout expires. It sits between control logic and the SR flip-flop bank and acts as that bank's writer.

---
 rtl/sr_bank_driver_pkg.sv | 36 +++
 rtl/sr_bank_driver_if.sv | 33 +++
 rtl/sr_bank_driver_excite_enc.sv | 36 +++
 rtl/sr_bank_driver.sv | 148 ++++++++++++++
 tb/tb_sr_bank_driver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sr_bank_driver_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types and constants for the SR flip-flop bank driver.
//   state_t   : driver FSM states (IDLE, DRIVE, WAIT)
//   sr_code_t : per-bit {s, r} excitation code
//   sr_code() : excitation needed to move one bit from q to its target
// -----------------------------------------------------------------------------
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef logic [1:0] sr_code_t;

    // {s, r} codes. SR_INV must never reach the bank.
    localparam sr_code_t SR_HOLD = 2'b00;
    localparam sr_code_t SR_RST  = 2'b01;
    localparam sr_code_t SR_SET  = 2'b10;
    localparam sr_code_t SR_INV  = 2'b11;

    // A bit already at its target holds; otherwise set or reset toward it.
    // SR_INV is structurally unreachable from here.
    function automatic sr_code_t sr_code(input logic t, input logic q);
        if (t == q) begin
            return SR_HOLD;
        end else if (t) begin
            return SR_SET;
        end else begin
            return SR_RST;
        end
    endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// -----------------------------------------------------------------------------
// sr_bank_driver_if
// Bundles the target handshake, bank excitation/feedback and status signals
// of sr_bank_driver.
//   master : upstream control + SR bank (offers targets, returns q_fb)
//   slave  : the driver itself
// Signals: tgt_valid/tgt_data/tgt_ready (target handshake), q_fb (bank state),
//          s/r (excitation), busy/done/err/err_bits (status).
// -----------------------------------------------------------------------------
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] err_bits;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, s, r, busy, done, err, err_bits
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, s, r, busy, done, err, err_bits
    );
endinterface

// File: rtl/sr_bank_driver_excite_enc.sv
// -----------------------------------------------------------------------------
// sr_excite_enc
// Combinational per-bit SR excitation encoder.
// Ports:
//   i_target   : desired bank state
//   i_q        : current bank state
//   o_s / o_r  : set / reset excitation (never both high on one bit)
//   o_diff_any : at least one bit differs from its target
// -----------------------------------------------------------------------------
import sr_drv_pkg::*;

module sr_excite_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_s,
    output logic [WIDTH-1:0] o_r,
    output logic             o_diff_any
);

    always_comb begin
        sr_code_t w_code;
        o_s    = '0;
        o_r    = '0;
        w_code = SR_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            w_code = sr_code(i_target[i], i_q[i]);
            o_s[i] = w_code[1];
            o_r[i] = w_code[0];
        end
    end

    assign o_diff_any = |(i_target ^ i_q);

endmodule

// File: rtl/sr_bank_driver.sv
// -----------------------------------------------------------------------------
// sr_bank_driver
// Writer for a bank of SR flip-flops. Accepts a target word, drives the
// per-bit set/reset excitation for exactly one cycle, then watches q_fb until
// it matches the target (done) or TIMEOUT wait cycles elapse (err).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : sr_bank_driver_if.slave (handshake, s/r, q_fb, status)
// Parameters:
//   WIDTH   : number of SR flip-flops (>= 1)
//   TIMEOUT : maximum WAIT cycles before err (>= 1)
// -----------------------------------------------------------------------------
import sr_drv_pkg::*;

module sr_bank_driver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                reset,
    sr_bank_driver_if.slave     bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_target, w_target_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0]   r_s,      w_s_nxt;
    logic [WIDTH-1:0]   r_r,      w_r_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_err,    w_err_nxt;
    logic [WIDTH-1:0]   r_err_bits, w_err_bits_nxt;
    // Low during reset and set on the first edge after release, so that
    // tgt_ready stays registered-only and is 0 while reset is held.
    logic               r_live;

    logic               w_ready;
    logic [WIDTH-1:0]   w_enc_tgt;
    logic [WIDTH-1:0]   w_enc_s;
    logic [WIDTH-1:0]   w_enc_r;
    logic               w_diff_any;

    // One encoder serves both acceptance (compare against the offered word)
    // and WAIT (compare against the held target).
    assign w_enc_tgt = (r_state == IDLE) ? bus.tgt_data : r_target;

    sr_excite_enc #(.WIDTH(WIDTH)) u_enc (
        .i_target   (w_enc_tgt),
        .i_q        (bus.q_fb),
        .o_s        (w_enc_s),
        .o_r        (w_enc_r),
        .o_diff_any (w_diff_any)
    );

    assign w_ready = (r_state == IDLE) && r_live;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_cnt      <= '0;
            r_s        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_bits <= '0;
            r_live     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_cnt      <= w_cnt_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_bits <= w_err_bits_nxt;
            r_live     <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_cnt_nxt      = r_cnt;
        w_s_nxt        = '0;
        w_r_nxt        = '0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_bits_nxt = r_err_bits;

        case (r_state)
            IDLE: begin
                if (bus.tgt_valid && w_ready) begin
                    w_target_nxt = bus.tgt_data;
                    if (!w_diff_any) begin
                        // Bank already matches: complete without driving.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_s_nxt     = w_enc_s;
                        w_r_nxt     = w_enc_r;
                        w_state_nxt = DRIVE;
                    end
                end
            end

            DRIVE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_W'(1);
            end

            WAIT: begin
                if (!w_diff_any) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_err_nxt      = 1'b1;
                    w_err_bits_nxt = bus.q_fb ^ r_target;
                    w_state_nxt    = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tgt_ready = w_ready;
    assign bus.busy      = (r_state != IDLE);
    assign bus.s         = r_s;
    assign bus.r         = r_r;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_bits  = r_err_bits;

    for (genvar g = 0; g < WIDTH; g++) begin : g_no_inv
        a_no_inv: assert property (@(posedge clk) disable iff (!reset)
                                   {r_s[g], r_r[g]} != SR_INV);
    end

    a_done_err_excl: assert property (@(posedge clk) disable iff (!reset)
                                      !(r_done && r_err));

endmodule

// File: tb/tb_sr_bank_driver.sv
module tb_sr_bank_driver;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic clk;
    logic reset;

    sr_bank_driver_if #(.WIDTH(WIDTH)) bus ();

    sr_bank_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SR bank: load port for presetting, stuck-at-0 mask on q.
    logic [WIDTH-1:0] bank_q;
    logic             bank_load;
    logic [WIDTH-1:0] bank_load_val;
    logic [WIDTH-1:0] stuck0;

    always @(posedge clk) begin
        if (bank_load) bank_q <= bank_load_val;
        else           bank_q <= (bank_q & ~bus.r) | bus.s;
    end

    assign bus.q_fb = bank_q & ~stuck0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [WIDTH-1:0] v);
        bank_load     = 1'b1;
        bank_load_val = v;
        @(negedge clk);
        bank_load     = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;
        bank_load     = 1'b1;
        bank_load_val = '0;
        stuck0        = '0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_ready",    bus.tgt_ready, 0);
        chk("rst_s",        bus.s,         0);
        chk("rst_r",        bus.r,         0);
        chk("rst_done",     bus.done,      0);
        chk("rst_err",      bus.err,       0);
        chk("rst_busy",     bus.busy,      0);
        chk("rst_err_bits", bus.err_bits,  0);
        reset     = 1'b1;
        bank_load = 1'b0;
        @(negedge clk);
        chk("rel_ready", bus.tgt_ready, 1);

        // Basic drive: bank 00 -> A5
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hA5;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("basic_s",     bus.s,         8'hA5);
        chk("basic_r",     bus.r,         8'h00);
        chk("basic_busy",  bus.busy,      1);
        chk("basic_ready", bus.tgt_ready, 0);
        @(negedge clk);
        chk("basic_wait_s",    bus.s,    0);
        chk("basic_wait_r",    bus.r,    0);
        chk("basic_wait_done", bus.done, 0);
        @(negedge clk);
        chk("basic_done",      bus.done,      1);
        chk("basic_done_rdy",  bus.tgt_ready, 1);
        chk("basic_done_busy", bus.busy,      0);
        @(negedge clk);
        chk("basic_done_clr", bus.done, 0);

        // Mixed excitation: bank F0 -> 3C
        preload(8'hF0);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h3C;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("mix_s",   bus.s,          8'h0C);
        chk("mix_r",   bus.r,          8'hC0);
        chk("mix_and", bus.s & bus.r,  0);
        @(negedge clk);
        @(negedge clk);
        chk("mix_done", bus.done, 1);
        chk("mix_err",  bus.err,  0);

        // No-op target: bank 55 -> 55
        preload(8'h55);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h55;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("noop_s",    bus.s,         0);
        chk("noop_r",    bus.r,         0);
        chk("noop_busy", bus.busy,      0);
        chk("noop_done", bus.done,      1);
        chk("noop_rdy",  bus.tgt_ready, 1);
        @(negedge clk);
        chk("noop_done_clr", bus.done, 0);

        // Stuck bit 3 at 0: target 08 times out
        preload(8'h00);
        stuck0        = 8'h08;
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h08;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("stuck_s", bus.s, 8'h08);
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            chk($sformatf("stuck_noerr%0d", i),  bus.err,  0);
            chk($sformatf("stuck_nodone%0d", i), bus.done, 0);
        end
        @(negedge clk);
        chk("stuck_err",      bus.err,       1);
        chk("stuck_err_bits", bus.err_bits,  8'h08);
        chk("stuck_done",     bus.done,      0);
        chk("stuck_rdy",      bus.tgt_ready, 1);
        @(negedge clk);
        chk("stuck_err_clr",   bus.err,      0);
        chk("stuck_bits_hold", bus.err_bits, 8'h08);
        stuck0 = '0;

        // Reset during WAIT
        preload(8'h00);
        stuck0        = 8'hFF;
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hFF;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("abort_drive_s", bus.s, 8'hFF);
        @(negedge clk);
        chk("abort_in_wait", bus.busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_s",        bus.s,         0);
        chk("abort_r",        bus.r,         0);
        chk("abort_done",     bus.done,      0);
        chk("abort_err",      bus.err,       0);
        chk("abort_busy",     bus.busy,      0);
        chk("abort_rdy",      bus.tgt_ready, 0);
        chk("abort_err_bits", bus.err_bits,  0);
        reset  = 1'b1;
        stuck0 = '0;
        @(negedge clk);
        chk("abort_rel_rdy",  bus.tgt_ready, 1);
        chk("abort_rel_done", bus.done,      0);
        chk("abort_rel_err",  bus.err,       0);

        // Back-to-back: second target offered while first completes
        preload(8'h00);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'h0F;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("b2b_s1", bus.s, 8'h0F);
        @(negedge clk);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hF0;
        @(negedge clk);
        chk("b2b_done1", bus.done,      1);
        chk("b2b_rdy1",  bus.tgt_ready, 1);
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("b2b_busy2", bus.busy, 1);
        chk("b2b_s2",    bus.s,    8'hF0);
        chk("b2b_r2",    bus.r,    8'h0F);
        chk("b2b_ndone", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done2", bus.done, 1);
        chk("b2b_bank",  bus.q_fb, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
